// File: rtl/chip8_alu_sequencer_pkg.sv
// Shared types for the Chip-8 8XYN sequencer: ALU function select, sequencer
// states and the operand/flag routing codes produced by the opcode decoder.
package chip8_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_f_OR,
    ALU_f_AND,
    ALU_f_XOR,
    ALU_f_ADD,
    ALU_f_MINUS,
    ALU_f_RSHIFT,
    ALU_f_LSHIFT
  } ALU_f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_EXEC,
    S_WB_X,
    S_WB_F,
    S_DONE,
    S_ERR
  } ALU_SEQ_state;

  typedef enum logic [2:0] {
    FLAG_NONE,
    FLAG_HI_BYTE,
    FLAG_CARRY,
    FLAG_SRC_LSB,
    FLAG_SRC_MSB
  } flag_src_t;

  typedef enum logic [1:0] {
    IN2_OTHER,
    IN2_ZERO,
    IN2_ONE
  } in2_src_t;

endpackage

// File: rtl/chip8_alu_op_decode.sv
// Combinational decode of the 8XYN N nibble into ALU select, operand routing
// and flag behaviour.
module chip8_alu_op_decode
  import chip8_alu_sequencer_pkg::*;
#(
  parameter logic VF_RESET_QUIRK = 1'b0,
  parameter logic SHIFT_USES_VY  = 1'b0
) (
  input  logic [3:0] n,
  output ALU_f       sel,
  output logic       swap,
  output in2_src_t   in2_src,
  output flag_src_t  flag_src,
  output logic       writes_vf,
  output logic       legal
);

  // swap routes Vy to input1; IN2_OTHER then takes whichever register input1 did not
  always_comb begin
    sel       = ALU_f_OR;
    swap      = 1'b0;
    in2_src   = IN2_OTHER;
    flag_src  = FLAG_NONE;
    writes_vf = 1'b0;
    legal     = 1'b1;
    case (n)
      4'h0: begin swap = 1'b1; in2_src = IN2_ZERO; end
      4'h1: writes_vf = VF_RESET_QUIRK;
      4'h2: begin sel = ALU_f_AND; writes_vf = VF_RESET_QUIRK; end
      4'h3: begin sel = ALU_f_XOR; writes_vf = VF_RESET_QUIRK; end
      4'h4: begin sel = ALU_f_ADD; flag_src = FLAG_HI_BYTE; writes_vf = 1'b1; end
      4'h5: begin sel = ALU_f_MINUS; flag_src = FLAG_CARRY; writes_vf = 1'b1; end
      4'h7: begin
        sel = ALU_f_MINUS; swap = 1'b1; flag_src = FLAG_CARRY; writes_vf = 1'b1;
      end
      4'h6: begin
        sel = ALU_f_RSHIFT; swap = SHIFT_USES_VY; in2_src = IN2_ONE;
        flag_src = FLAG_SRC_LSB; writes_vf = 1'b1;
      end
      4'hE: begin
        sel = ALU_f_LSHIFT; swap = SHIFT_USES_VY; in2_src = IN2_ONE;
        flag_src = FLAG_SRC_MSB; writes_vf = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// Sequences one Chip-8 8XYN instruction: read Vx/Vy, drive the external ALU,
// write the result to Vx and the flag to VF.
module chip8_alu_sequencer
  import chip8_alu_sequencer_pkg::*;
#(
  parameter logic VF_RESET_QUIRK = 1'b0,
  parameter logic SHIFT_USES_VY  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] opcode,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [3:0]  reg_rd_addr,
  input  logic [7:0]  reg_rd_data,
  output logic        reg_wr_en,
  output logic [3:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output ALU_f        alu_sel,
  input  logic [15:0] alu_out,
  input  logic        alu_carry
);

  ALU_SEQ_state state;
  logic [3:0]   x_q, y_q, n_q, dec_n;
  logic [7:0]   vx_q, res_q, op_a, op_b;
  logic         flag_q, flag_c;

  ALU_f      dec_sel;
  logic      dec_swap, dec_writes_vf, dec_legal;
  in2_src_t  dec_in2_src;
  flag_src_t dec_flag_src;

  // In IDLE the decoder looks at the incoming opcode so legality is known at accept
  assign dec_n = (state == S_IDLE) ? opcode[3:0] : n_q;

  chip8_alu_op_decode #(
    .VF_RESET_QUIRK(VF_RESET_QUIRK),
    .SHIFT_USES_VY (SHIFT_USES_VY)
  ) u_decode (
    .n        (dec_n),
    .sel      (dec_sel),
    .swap     (dec_swap),
    .in2_src  (dec_in2_src),
    .flag_src (dec_flag_src),
    .writes_vf(dec_writes_vf),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      vx_q   <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x_q   <= opcode[11:8];
          y_q   <= opcode[7:4];
          n_q   <= opcode[3:0];
          state <= (opcode[15:12] == 4'h8 && dec_legal) ? S_RD_X : S_ERR;
        end
        S_RD_X: state <= S_RD_Y;
        S_RD_Y: begin
          vx_q  <= reg_rd_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          res_q  <= alu_out[7:0];
          flag_q <= flag_c;
          state  <= S_WB_X;
        end
        S_WB_X:  state <= S_WB_F;
        S_WB_F:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // In EXEC reg_rd_data carries Vy while vx_q holds Vx
  assign op_a = dec_swap ? reg_rd_data : vx_q;
  assign op_b = dec_swap ? vx_q : reg_rd_data;

  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE) || (state == S_ERR);
    illegal     = (state == S_ERR);
    reg_rd_addr = '0;
    reg_wr_en   = 1'b0;
    reg_wr_addr = '0;
    reg_wr_data = '0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_sel     = ALU_f_OR;
    flag_c      = 1'b0;
    case (state)
      S_RD_X: reg_rd_addr = x_q;
      S_RD_Y: reg_rd_addr = y_q;
      S_EXEC: begin
        alu_in1 = {8'h00, op_a};
        alu_sel = dec_sel;
        case (dec_in2_src)
          IN2_ZERO: alu_in2 = '0;
          IN2_ONE:  alu_in2 = 16'd1;
          default:  alu_in2 = {8'h00, op_b};
        endcase
        case (dec_flag_src)
          FLAG_HI_BYTE: flag_c = |alu_out[15:8];
          FLAG_CARRY:   flag_c = alu_carry;
          FLAG_SRC_LSB: flag_c = op_a[0];
          FLAG_SRC_MSB: flag_c = op_a[7];
          default:      flag_c = 1'b0;
        endcase
      end
      S_WB_X: begin
        reg_wr_en   = 1'b1;
        reg_wr_addr = x_q;
        reg_wr_data = res_q;
      end
      S_WB_F: if (dec_writes_vf) begin
        reg_wr_en   = 1'b1;
        reg_wr_addr = 4'hF;
        reg_wr_data = {7'b0, flag_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Bench for chip8_alu_sequencer: two parameterisations side by side, each with
// its own register file and ALU model, checked against an instruction-level model.
module tb_chip8_alu_sequencer;
  import chip8_alu_sequencer_pkg::*;

  typedef struct {
    logic [7:0]  res;
    logic        flag;
    logic        wvf;
    ALU_f        sel;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opcode = '0;

  logic        busy[2], done[2], illegal[2], wr_en[2], acar[2];
  logic [3:0]  rd_addr[2], wr_addr[2];
  logic [7:0]  rd_data[2], wr_data[2];
  logic [15:0] in1[2], in2[2], aout[2];
  ALU_f        sel[2];
  logic [7:0]  rf[2][16];
  int          wcount[2] = '{0, 0};

  logic        poke_en = 1'b0;
  logic [3:0]  poke_addr = '0;
  logic [7:0]  poke_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  chip8_alu_sequencer #(.VF_RESET_QUIRK(1'b0), .SHIFT_USES_VY(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .busy(busy[0]), .done(done[0]), .illegal(illegal[0]),
    .reg_rd_addr(rd_addr[0]), .reg_rd_data(rd_data[0]),
    .reg_wr_en(wr_en[0]), .reg_wr_addr(wr_addr[0]), .reg_wr_data(wr_data[0]),
    .alu_in1(in1[0]), .alu_in2(in2[0]), .alu_sel(sel[0]),
    .alu_out(aout[0]), .alu_carry(acar[0]));

  chip8_alu_sequencer #(.VF_RESET_QUIRK(1'b1), .SHIFT_USES_VY(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .busy(busy[1]), .done(done[1]), .illegal(illegal[1]),
    .reg_rd_addr(rd_addr[1]), .reg_rd_data(rd_data[1]),
    .reg_wr_en(wr_en[1]), .reg_wr_addr(wr_addr[1]), .reg_wr_data(wr_data[1]),
    .alu_in1(in1[1]), .alu_in2(in2[1]), .alu_sel(sel[1]),
    .alu_out(aout[1]), .alu_carry(acar[1]));

  function automatic logic [16:0] alu_fn(input ALU_f s, input logic [15:0] a, input logic [15:0] b);
    case (s)
      ALU_f_OR:     return {1'b0, a | b};
      ALU_f_AND:    return {1'b0, a & b};
      ALU_f_XOR:    return {1'b0, a ^ b};
      ALU_f_ADD:    return {1'b0, a + b};
      ALU_f_MINUS:  return {a > b, a - b};
      ALU_f_RSHIFT: return {1'b0, a >> b};
      ALU_f_LSHIFT: return {1'b0, a << b};
      default:      return '0;
    endcase
  endfunction

  assign {acar[0], aout[0]} = alu_fn(sel[0], in1[0], in2[0]);
  assign {acar[1], aout[1]} = alu_fn(sel[1], in1[1], in2[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i]) begin
        rf[i][wr_addr[i]] <= wr_data[i];
        wcount[i] <= wcount[i] + 1;
      end
      if (poke_en) rf[i][poke_addr] <= poke_data;
      rd_data[i] <= rf[i][rd_addr[i]];
    end
  end

  function automatic bit legal_fn(input logic [15:0] opc);
    return opc[15:12] == 4'h8 && (opc[3:0] <= 4'h7 || opc[3:0] == 4'hE);
  endfunction

  function automatic exp_t model(input logic [15:0] opc, input logic [7:0] vx, input logic [7:0] vy,
                                 input bit quirk, input bit shvy);
    exp_t e;
    logic [8:0] s;
    logic [7:0] src;
    e.res = '0; e.flag = 1'b0; e.wvf = 1'b0; e.sel = ALU_f_OR;
    e.a = {8'h00, vx}; e.b = {8'h00, vy};
    src = shvy ? vy : vx;
    case (opc[3:0])
      4'h0: begin e.res = vy; e.a = {8'h00, vy}; e.b = '0; end
      4'h1: begin e.res = vx | vy; e.wvf = quirk; end
      4'h2: begin e.res = vx & vy; e.wvf = quirk; e.sel = ALU_f_AND; end
      4'h3: begin e.res = vx ^ vy; e.wvf = quirk; e.sel = ALU_f_XOR; end
      4'h4: begin
        s = {1'b0, vx} + {1'b0, vy};
        e.res = s[7:0]; e.flag = s[8]; e.wvf = 1'b1; e.sel = ALU_f_ADD;
      end
      4'h5: begin e.res = vx - vy; e.flag = vx > vy; e.wvf = 1'b1; e.sel = ALU_f_MINUS; end
      4'h7: begin
        e.res = vy - vx; e.flag = vy > vx; e.wvf = 1'b1; e.sel = ALU_f_MINUS;
        e.a = {8'h00, vy}; e.b = {8'h00, vx};
      end
      4'h6: begin
        e.res = src >> 1; e.flag = src[0]; e.wvf = 1'b1; e.sel = ALU_f_RSHIFT;
        e.a = {8'h00, src}; e.b = 16'd1;
      end
      4'hE: begin
        e.res = src << 1; e.flag = src[7]; e.wvf = 1'b1; e.sel = ALU_f_LSHIFT;
        e.a = {8'h00, src}; e.b = 16'd1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d @%0t: got %h want %h", nm, idx, $time, act, exp);
    end
  endtask

  // Cycle-level expectation: phase counts cycles since an accepted start
  int         phase = 0;
  int         op_len = 0;
  logic       exp_ill = 1'b0;
  logic [3:0] ex_x = '0, ex_y = '0;
  exp_t       ex_st[2];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase <= 0;
    else if (phase != 0) phase <= (phase == op_len) ? 0 : phase + 1;
    else if (start) begin
      phase   <= 1;
      op_len  <= legal_fn(opcode) ? 6 : 1;
      exp_ill <= !legal_fn(opcode);
      ex_x    <= opcode[11:8];
      ex_y    <= opcode[7:4];
      for (int i = 0; i < 2; i++)
        ex_st[i] <= model(opcode, rf[i][opcode[11:8]], rf[i][opcode[7:4]], i == 1, i == 1);
    end
  end

  logic c_done, c_wr;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_done = (phase != 0) && (phase == op_len);
      c_wr   = !exp_ill && (phase == 4 || (phase == 5 && ex_st[i].wvf));
      chk("busy", i, 32'(busy[i]), 32'(phase != 0));
      chk("done", i, 32'(done[i]), 32'(c_done));
      chk("illegal", i, 32'(illegal[i]), 32'(c_done && exp_ill));
      chk("wr_en", i, 32'(wr_en[i]), 32'(c_wr));
      if (!exp_ill && phase == 1) chk("rd_addr_x", i, 32'(rd_addr[i]), 32'(ex_x));
      if (!exp_ill && phase == 2) chk("rd_addr_y", i, 32'(rd_addr[i]), 32'(ex_y));
      if (!exp_ill && phase == 4) begin
        chk("wr_addr_x", i, 32'(wr_addr[i]), 32'(ex_x));
        chk("wr_data_x", i, 32'(wr_data[i]), 32'(ex_st[i].res));
      end
      if (c_wr && phase == 5) begin
        chk("wr_addr_f", i, 32'(wr_addr[i]), 32'hF);
        chk("wr_data_f", i, 32'(wr_data[i]), 32'(ex_st[i].flag));
      end
      if (!exp_ill && phase == 3) begin
        chk("alu_in1", i, 32'(in1[i]), 32'(ex_st[i].a));
        chk("alu_in2", i, 32'(in2[i]), 32'(ex_st[i].b));
        chk("alu_sel", i, 32'(sel[i]), 32'(ex_st[i].sel));
      end else begin
        chk("alu_in1_idle", i, 32'(in1[i]), 32'h0);
        chk("alu_in2_idle", i, 32'(in2[i]), 32'h0);
        chk("alu_sel_idle", i, 32'(sel[i]), 32'(ALU_f_OR));
      end
      if (!reset_n) begin
        chk("rst_rd_addr", i, 32'(rd_addr[i]), 32'h0);
        chk("rst_wr_addr", i, 32'(wr_addr[i]), 32'h0);
        chk("rst_wr_data", i, 32'(wr_data[i]), 32'h0);
      end
    end
  end

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic cmp_rf(input string nm, input logic [7:0] em[2][16]);
    int k;
    for (int i = 0; i < 2; i++) begin
      k = 0;
      for (int j = 15; j >= 0; j--) if (rf[i][j] !== em[i][j]) k = j;
      chk(nm, i, 32'(rf[i][k]), 32'(em[i][k]));
    end
  endtask

  task automatic do_op(input logic [15:0] opc, input bit inject);
    logic [7:0] em[2][16];
    int base[2], ewc[2];
    int cyc;
    bit lg;
    exp_t e;
    lg = legal_fn(opc);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) em[i][j] = rf[i][j];
      base[i] = wcount[i];
      e = model(opc, rf[i][opc[11:8]], rf[i][opc[7:4]], i == 1, i == 1);
      ewc[i] = 0;
      if (lg) begin
        em[i][opc[11:8]] = e.res;
        ewc[i] = 1;
        if (e.wvf) begin em[i][15] = {7'b0, e.flag}; ewc[i] = 2; end
      end
    end
    @(negedge clk);
    start = 1'b1; opcode = opc;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done[0] && cyc < 20) begin
      if (inject && cyc == 2) begin start = 1'b1; opcode = 16'h8FF4; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 0, 32'(cyc), lg ? 32'd6 : 32'd1);
    @(negedge clk);
    cmp_rf("regfile", em);
    for (int i = 0; i < 2; i++) chk("wr_count", i, 32'(wcount[i] - base[i]), 32'(ewc[i]));
  endtask

  task automatic reset_mid_op();
    logic [7:0] em[2][16];
    int base[2];
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) em[i][j] = rf[i][j];
      base[i] = wcount[i];
    end
    @(negedge clk);
    start = 1'b1; opcode = 16'h8124;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    cmp_rf("rst_regfile", em);
    for (int i = 0; i < 2; i++) chk("rst_wr_count", i, 32'(wcount[i] - base[i]), 32'h0);
  endtask

  logic [3:0] legal_n[9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};

  initial begin
    logic [15:0] opc;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 16; j++) poke(4'(j), 8'(j * 17));

    poke(4'h1, 8'hF0); poke(4'h2, 8'h20);
    do_op(16'h8124, 1'b1);
    chk("add_v1", 0, 32'(rf[0][1]), 32'h10);
    chk("add_vf", 0, 32'(rf[0][15]), 32'h01);
    poke(4'h1, 8'h01); poke(4'h2, 8'h02);
    do_op(16'h8124, 1'b0);
    chk("add2_v1", 1, 32'(rf[1][1]), 32'h03);
    chk("add2_vf", 1, 32'(rf[1][15]), 32'h00);

    poke(4'h3, 8'h10); poke(4'h4, 8'h20);
    do_op(16'h8345, 1'b0);
    chk("sub_v3", 0, 32'(rf[0][3]), 32'hF0);
    chk("sub_vf", 0, 32'(rf[0][15]), 32'h00);
    poke(4'h3, 8'h10); poke(4'h4, 8'h20);
    do_op(16'h8347, 1'b0);
    chk("subn_v3", 0, 32'(rf[0][3]), 32'h10);
    chk("subn_vf", 0, 32'(rf[0][15]), 32'h01);

    poke(4'h5, 8'h81);
    do_op(16'h8506, 1'b0);
    chk("shr_v5", 0, 32'(rf[0][5]), 32'h40);
    chk("shr_vf", 0, 32'(rf[0][15]), 32'h01);
    poke(4'h5, 8'h81);
    do_op(16'h850E, 1'b0);
    chk("shl_v5", 0, 32'(rf[0][5]), 32'h02);
    chk("shl_vf", 0, 32'(rf[0][15]), 32'h01);
    poke(4'h5, 8'h81); poke(4'h6, 8'h03);
    do_op(16'h856E, 1'b0);
    chk("shl_vy_v5", 1, 32'(rf[1][5]), 32'h06);
    chk("shl_vy_vf", 1, 32'(rf[1][15]), 32'h00);

    poke(4'hF, 8'hFF); poke(4'hE, 8'h01);
    do_op(16'h8FE4, 1'b0);
    chk("vf_dest", 0, 32'(rf[0][15]), 32'h01);
    poke(4'hF, 8'hAA); poke(4'h1, 8'h0F); poke(4'h2, 8'hF0);
    do_op(16'h8121, 1'b0);
    chk("or_v1", 0, 32'(rf[0][1]), 32'hFF);
    chk("or_vf_keep", 0, 32'(rf[0][15]), 32'hAA);
    chk("or_vf_quirk", 1, 32'(rf[1][15]), 32'h00);

    do_op(16'h8128, 1'b0);
    do_op(16'h7123, 1'b0);

    poke(4'h1, 8'hF0); poke(4'h2, 8'h20);
    reset_mid_op();
    do_op(16'h8124, 1'b0);
    chk("post_rst_v1", 0, 32'(rf[0][1]), 32'h10);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) poke(4'($urandom), 8'($urandom));
      if ($urandom_range(0, 9) == 0) opc = 16'($urandom);
      else opc = {4'h8, 4'($urandom), 4'($urandom), legal_n[$urandom_range(0, 8)]};
      do_op(opc, $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_alu_sequencer.md
Name: chip8_alu_sequencer

Overview:
Executes Chip-8 8XYN register-register instructions for the CPU.
- Reads Vx and Vy from the V register file.
- Drives the shared Chip8_ALU combinationally.
- Writes the 8-bit result back to Vx, then writes VF where the opcode defines a flag.
- Sits between the CPU fetch/decode FSM (start/done handshake) and the register file plus ALU (which stays a separate instance).

Parameters:
- VF_RESET_QUIRK, 0: when 1, OR/AND/XOR (N=1,2,3) also write VF=0.
- SHIFT_USES_VY, 0: when 1, shifts (N=6,E) take their source from Vy instead of Vx.

Ports:
- clk  input  1  CPU clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- opcode  input  16  instruction, captured on accepted start
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- illegal  output  1  high together with done when the opcode was rejected
- reg_rd_addr  output  4  register file read address
- reg_rd_data  input  8  register file read data, valid 1 cycle after address
- reg_wr_en  output  1  register write strobe
- reg_wr_addr  output  4  write address
- reg_wr_data  output  8  write data
- alu_in1  output  16  to ALU input1, zero-extended
- alu_in2  output  16  to ALU input2, zero-extended
- alu_sel  output  ALU_f  ALU function select
- alu_out  input  16  from ALU
- alu_carry  input  1  from ALU

Behaviour:
Reset:
- State goes to IDLE.
- busy, done, illegal, reg_wr_en = 0; all addresses and data = 0; alu_sel = ALU_f_OR.
- A reset mid-operation aborts the instruction. No further writes occur.

States: IDLE, RD_X, RD_Y, EXEC, WB_X, WB_F, DONE, ERR.
- IDLE: on start, capture opcode (X = [11:8], Y = [7:4], N = [3:0]).
  - opcode[15:12] != 8, or N not in {0,1,2,3,4,5,6,7,E}: go to ERR.
  - Otherwise go to RD_X.
- RD_X: reg_rd_addr = X.
- RD_Y: capture reg_rd_data into vx_q; reg_rd_addr = Y.
- EXEC: reg_rd_data is Vy. Drive the ALU combinationally; latch res_q = alu_out[7:0] and flag_q.
- WB_X: write res_q to X.
- WB_F: write flag_q to register F only if the op defines a flag; otherwise reg_wr_en = 0.
- DONE: done = 1, then return to IDLE.
- ERR: done = 1, illegal = 1, no register access, then return to IDLE.

Latency and handshake:
- Fixed latency. If start is sampled at edge 0, done is high in the 6th cycle after it, i.e. the cycle following edge 5. ERR gives done 1 cycle after start.
- start while busy is ignored.
- done and start in the same cycle: start is not accepted, since the state is not IDLE.

Operation map (in1, in2, sel → flag):
- 0 LD: Vy, 0, OR → no flag.
- 1 OR: Vx, Vy, OR → no flag.
- 2 AND: Vx, Vy, AND → no flag.
- 3 XOR: Vx, Vy, XOR → no flag.
- 4 ADD: Vx, Vy, ADD → flag = |alu_out[15:8]. alu_carry is ignored for ADD.
- 5 SUB: Vx, Vy, MINUS → flag = alu_carry (Vx > Vy).
- 7 SUBN: Vy, Vx, MINUS → flag = alu_carry (Vy > Vx).
- 6 SHR: src, 1, RSHIFT → flag = src[0].
- E SHL: src, 1, LSHIFT → flag = src[7].
- src = Vx, or Vy when SHIFT_USES_VY = 1.
- Result width: results are truncated to 8 bits, so wrap-around is natural (e.g. 0x10 − 0x20 = 0xF0).

Boundary cases:
- X == Y: both reads return the same value; no special casing.
- X == F with a flag op: the flag write in WB_F overwrites the result, so the flag wins.
- Outside EXEC: ALU inputs are held at 0 and alu_sel at ALU_f_OR.

Decomposition:
- Add the state enum ALU_SEQ_state to enums.svh, beside ALU_f.
- One sub-module: chip8_alu_op_decode. It is combinational and maps N plus both parameters to {sel, swap, flag_src, writes_vf, legal}.
- The Chip8_ALU is instanced by the CPU top, not inside this block.

Test Plan:
- ADD with V1 = 0xF0, V2 = 0x20, opcode 0x8124 → V1 = 0x10, VF = 1, done exactly 6 cycles after start. Then V1 = 0x01, V2 = 0x02 → V1 = 0x03, VF = 0.
- SUB/SUBN with V3 = 0x10, V4 = 0x20, opcode 0x8345 → V3 = 0xF0, VF = 0. Then reset regs and opcode 0x8347 → V3 = 0x10, VF = 1.
- Shifts with V5 = 0x81: opcode 0x8506 → V5 = 0x40, VF = 1. Opcode 0x850E on 0x81 → V5 = 0x02, VF = 1. Repeat with SHIFT_USES_VY = 1 and V6 = 0x03, opcode 0x856E → V5 = 0x06, VF = 0.
- Flag-register destination with VF = 0xFF, VE = 0x01, opcode 0x8FE4 → final VF = 0x01 (flag wins, not the sum 0x00). OR/AND/XOR leave VF unchanged with quirk 0, and write VF = 0 with quirk 1.
- Illegal opcodes 0x8128 and 0x7123 → done and illegal high 1 cycle after start, zero reg_wr_en pulses. A start pulsed while busy is ignored and the first result is unaffected.
- Reset mid-operation: assert reset_n = 0 during EXEC of 0x8124 → no write occurs, outputs return to 0, and the next start executes normally.
